// File: rtl/traffic_ctrl_np.sv
// N-phase traffic-signal controller: demand-driven round-robin greens with
// yellow and all-red clearance, internal countdown, and flashing-yellow night mode.
module traffic_ctrl_np #(
    parameter int NPH = 4,
    parameter int PW  = 2,
    parameter int TW  = 6,
    parameter int YT  = 3,
    parameter int RT  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                TICK,
    input  logic                FLASH,
    input  logic [NPH-1:0]      DET,
    input  logic [NPH*TW-1:0]   GT,
    output logic [NPH-1:0]      GRN,
    output logic [NPH-1:0]      YEL,
    output logic [NPH-1:0]      RED,
    output logic [PW-1:0]       PHASE,
    output logic [1:0]          STATE,
    output logic [TW-1:0]       REMAIN
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_ALLRED = 2'b10,
        S_FLASH  = 2'b11
    } state_t;

    localparam logic [TW-1:0] YT_LD = TW'(YT);
    localparam logic [TW-1:0] RT_LD = TW'(RT);
    localparam logic [TW-1:0] ONE   = TW'(1);

    state_t          st_reg;
    logic [PW-1:0]   ph_reg;
    logic [PW-1:0]   nxt_reg;
    logic [TW-1:0]   cnt_reg;
    logic            blink_reg;

    logic [TW-1:0]   gt_arr [NPH];
    logic [TW-1:0]   ld_ph;
    logic [TW-1:0]   ld_nxt;
    logic            found;
    logic [PW-1:0]   found_ph;
    int              idx;

    for (genvar gi = 0; gi < NPH; gi++) begin : g_gt
        assign gt_arr[gi] = GT[gi*TW +: TW];
    end

    // A programmed green time of zero still gives a one-tick green.
    assign ld_ph  = (gt_arr[ph_reg]  == '0) ? ONE : gt_arr[ph_reg];
    assign ld_nxt = (gt_arr[nxt_reg] == '0) ? ONE : gt_arr[nxt_reg];

    // Scan from farthest to nearest so the nearest demanding phase wins.
    always_comb begin
        found    = 1'b0;
        found_ph = ph_reg;
        idx      = 0;
        for (int k = NPH - 1; k >= 1; k--) begin
            idx = int'(ph_reg) + k;
            if (idx >= NPH) begin
                idx = idx - NPH;
            end
            if (DET[idx[PW-1:0]]) begin
                found    = 1'b1;
                found_ph = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_reg    <= S_ALLRED;
            ph_reg    <= '0;
            nxt_reg   <= '0;
            cnt_reg   <= RT_LD;
            blink_reg <= 1'b0;
        end else if (st_reg != S_FLASH && FLASH) begin
            st_reg    <= S_FLASH;
            blink_reg <= 1'b1;
            cnt_reg   <= '0;
        end else if (st_reg == S_FLASH) begin
            if (!FLASH) begin
                st_reg  <= S_ALLRED;
                cnt_reg <= RT_LD;
                nxt_reg <= '0;
            end else if (TICK) begin
                blink_reg <= ~blink_reg;
            end
        end else if (TICK) begin
            if (cnt_reg > ONE) begin
                cnt_reg <= cnt_reg - ONE;
            end else begin
                case (st_reg)
                    S_GREEN: begin
                        if (found) begin
                            st_reg  <= S_YELLOW;
                            nxt_reg <= found_ph;
                            cnt_reg <= YT_LD;
                        end else begin
                            cnt_reg <= ld_ph;
                        end
                    end
                    S_YELLOW: begin
                        st_reg  <= S_ALLRED;
                        cnt_reg <= RT_LD;
                    end
                    S_ALLRED: begin
                        st_reg  <= S_GREEN;
                        ph_reg  <= nxt_reg;
                        cnt_reg <= ld_nxt;
                    end
                    default: begin
                        st_reg <= S_ALLRED;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NPH; gi++) begin : g_lamp
        logic served;
        assign served   = (ph_reg == PW'(gi));
        assign GRN[gi]  = (st_reg == S_GREEN) && served;
        assign YEL[gi]  = ((st_reg == S_YELLOW) && served) ||
                          ((st_reg == S_FLASH) && blink_reg);
        assign RED[gi]  = (st_reg == S_ALLRED) ||
                          (((st_reg == S_GREEN) || (st_reg == S_YELLOW)) && !served);
    end

    assign PHASE  = ph_reg;
    assign STATE  = st_reg;
    assign REMAIN = cnt_reg;

endmodule

// File: tb/tb_traffic_ctrl_np.sv
// Directed bench for traffic_ctrl_np: reset, full cycle, skipping, rest-in-green,
// night flash and reset mid-yellow, all with hand-computed expected vectors.
module tb_traffic_ctrl_np;

    localparam int NPH = 4;
    localparam int PW  = 2;
    localparam int TW  = 6;
    localparam int YT  = 3;
    localparam int RT  = 1;

    logic              CLK;
    logic              RST;
    logic              TICK;
    logic              FLASH;
    logic [NPH-1:0]    DET;
    logic [NPH*TW-1:0] GT;
    logic [NPH-1:0]    GRN;
    logic [NPH-1:0]    YEL;
    logic [NPH-1:0]    RED;
    logic [PW-1:0]     PHASE;
    logic [1:0]        STATE;
    logic [TW-1:0]     REMAIN;

    int checks;
    int errors;

    logic [21:0] obs;
    logic [21:0] exp_v;

    traffic_ctrl_np #(.NPH(NPH), .PW(PW), .TW(TW), .YT(YT), .RT(RT)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .TICK   (TICK),
        .FLASH  (FLASH),
        .DET    (DET),
        .GT     (GT),
        .GRN    (GRN),
        .YEL    (YEL),
        .RED    (RED),
        .PHASE  (PHASE),
        .STATE  (STATE),
        .REMAIN (REMAIN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign obs = {STATE, PHASE, REMAIN, GRN, YEL, RED};

    // Expected {STATE, PHASE, REMAIN, GRN, YEL, RED} from the lamp table.
    function automatic logic [21:0] mk(input logic [1:0] s, input logic [1:0] p,
                                       input logic [5:0] r, input logic b);
        logic [3:0] oh;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] rd;
        oh = 4'b0001 << p;
        g  = 4'b0000;
        y  = 4'b0000;
        rd = 4'b0000;
        case (s)
            2'b00:   begin g = oh; rd = ~oh; end
            2'b01:   begin y = oh; rd = ~oh; end
            2'b10:   rd = 4'b1111;
            default: y = {4{b}};
        endcase
        return {s, p, r, g, y, rd};
    endfunction

    task automatic do_ticks(input int n);
        repeat (n) begin
            TICK = 1'b1;
            @(negedge CLK);
            TICK = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        FLASH = 1'b0;
        TICK  = 1'b0;
        DET   = 4'b1111;
        GT    = {6'd8, 6'd7, 6'd6, 6'd5};
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        exp_v = mk(2'b10, 2'd0, 6'd1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", obs, exp_v);
        end else $display("[%0t] reset_values obs=%h", $time, obs);
        do_ticks(1);
        exp_v = mk(2'b00, 2'd0, 6'd5, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_first_green: got %h want %h", obs, exp_v);
        end else $display("[%0t] reset_first_green obs=%h", $time, obs);
    endtask

    task automatic test_full_cycle();
        for (int p = 0; p < 4; p++) begin
            for (int r = p + 5; r >= 1; r--) begin
                exp_v = mk(2'b00, 2'(p), 6'(r), 1'b0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL cycle_green p%0d r%0d: got %h want %h", p, r, obs, exp_v);
                end else $display("[%0t] cycle_green p%0d r%0d obs=%h", $time, p, r, obs);
                do_ticks(1);
            end
            for (int r = 3; r >= 1; r--) begin
                exp_v = mk(2'b01, 2'(p), 6'(r), 1'b0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL cycle_yellow p%0d r%0d: got %h want %h", p, r, obs, exp_v);
                end else $display("[%0t] cycle_yellow p%0d r%0d obs=%h", $time, p, r, obs);
                do_ticks(1);
            end
            exp_v = mk(2'b10, 2'(p), 6'd1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL cycle_allred p%0d: got %h want %h", p, obs, exp_v);
            end else $display("[%0t] cycle_allred p%0d obs=%h", $time, p, obs);
            do_ticks(1);
        end
        exp_v = mk(2'b00, 2'd0, 6'd5, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL cycle_wrap: got %h want %h", obs, exp_v);
        end else $display("[%0t] cycle_wrap obs=%h", $time, obs);
    endtask

    task automatic test_skip();
        logic [21:0] want [4];
        string       nm   [4];
        DET = 4'b1001;
        do_ticks(5);
        want[0] = mk(2'b01, 2'd0, 6'd3, 1'b0); nm[0] = "skip_yellow";
        checks++;
        if (obs !== want[0]) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm[0], obs, want[0]);
        end else $display("[%0t] %s obs=%h", $time, nm[0], obs);
        DET = 4'b0001;
        do_ticks(3);
        want[1] = mk(2'b10, 2'd0, 6'd1, 1'b0); nm[1] = "skip_allred";
        checks++;
        if (obs !== want[1]) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm[1], obs, want[1]);
        end else $display("[%0t] %s obs=%h", $time, nm[1], obs);
        do_ticks(1);
        want[2] = mk(2'b00, 2'd3, 6'd8, 1'b0); nm[2] = "skip_to_phase3";
        checks++;
        if (obs !== want[2]) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm[2], obs, want[2]);
        end else $display("[%0t] %s obs=%h", $time, nm[2], obs);
        DET = 4'b0011;
        do_ticks(12);
        want[3] = mk(2'b00, 2'd0, 6'd5, 1'b0); nm[3] = "search_wraps_to_0";
        checks++;
        if (obs !== want[3]) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm[3], obs, want[3]);
        end else $display("[%0t] %s obs=%h", $time, nm[3], obs);
    endtask

    task automatic test_rest_zero();
        DET = 4'b0001;
        do_ticks(5);
        exp_v = mk(2'b00, 2'd0, 6'd5, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rest_reload: got %h want %h", obs, exp_v);
        end else $display("[%0t] rest_reload obs=%h", $time, obs);
        GT[5:0] = 6'd0;
        do_ticks(1);
        exp_v = mk(2'b00, 2'd0, 6'd4, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL gt_sampled_at_load: got %h want %h", obs, exp_v);
        end else $display("[%0t] gt_sampled_at_load obs=%h", $time, obs);
        do_ticks(4);
        exp_v = mk(2'b00, 2'd0, 6'd1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL zero_gt_load: got %h want %h", obs, exp_v);
        end else $display("[%0t] zero_gt_load obs=%h", $time, obs);
        do_ticks(1);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL zero_gt_repeat: got %h want %h", obs, exp_v);
        end else $display("[%0t] zero_gt_repeat obs=%h", $time, obs);
        GT[5:0] = 6'd5;
        do_ticks(1);
        exp_v = mk(2'b00, 2'd0, 6'd5, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL gt_restored: got %h want %h", obs, exp_v);
        end else $display("[%0t] gt_restored obs=%h", $time, obs);
    endtask

    task automatic test_flash();
        DET = 4'b0010;
        do_ticks(10);
        exp_v = mk(2'b00, 2'd1, 6'd5, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL flash_pre_green: got %h want %h", obs, exp_v);
        end else $display("[%0t] flash_pre_green obs=%h", $time, obs);
        FLASH = 1'b1;
        TICK  = 1'b1;
        @(negedge CLK);
        TICK  = 1'b0;
        exp_v = mk(2'b11, 2'd1, 6'd0, 1'b1);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL flash_entry: got %h want %h", obs, exp_v);
        end else $display("[%0t] flash_entry obs=%h", $time, obs);
        for (int i = 0; i < 4; i++) begin
            do_ticks(1);
            exp_v = mk(2'b11, 2'd1, 6'd0, (i % 2) == 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL flash_toggle %0d: got %h want %h", i, obs, exp_v);
            end else $display("[%0t] flash_toggle %0d obs=%h", $time, i, obs);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL flash_hold: got %h want %h", obs, exp_v);
        end else $display("[%0t] flash_hold obs=%h", $time, obs);
        FLASH = 1'b0;
        @(negedge CLK);
        exp_v = mk(2'b10, 2'd1, 6'd1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL flash_exit_allred: got %h want %h", obs, exp_v);
        end else $display("[%0t] flash_exit_allred obs=%h", $time, obs);
        DET = 4'b1111;
        do_ticks(1);
        exp_v = mk(2'b00, 2'd0, 6'd5, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL flash_resume_p0: got %h want %h", obs, exp_v);
        end else $display("[%0t] flash_resume_p0 obs=%h", $time, obs);
    endtask

    task automatic test_reset_mid_yellow();
        DET = 4'b1111;
        do_ticks(5 + 4 + 6 + 4 + 7 + 1);
        exp_v = mk(2'b01, 2'd2, 6'd2, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_yellow: got %h want %h", obs, exp_v);
        end else $display("[%0t] pre_reset_yellow obs=%h", $time, obs);
        RST = 1'b1;
        @(negedge CLK);
        exp_v = mk(2'b10, 2'd0, 6'd1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_yellow: got %h want %h", obs, exp_v);
        end else $display("[%0t] reset_mid_yellow obs=%h", $time, obs);
        RST = 1'b0;
        do_ticks(1);
        exp_v = mk(2'b00, 2'd0, 6'd5, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL resume_after_reset: got %h want %h", obs, exp_v);
        end else $display("[%0t] resume_after_reset obs=%h", $time, obs);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        TICK   = 1'b0;
        FLASH  = 1'b0;
        DET    = '0;
        GT     = '0;
        @(negedge CLK);
        test_reset();
        test_full_cycle();
        test_skip();
        test_rest_zero();
        test_flash();
        test_reset_mid_yellow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
